bram_dma_copy: RTL and testbench

- Block-move engine that drives one port of the 64KB lower-RAM block RAM. It sits directly upstream of that RAM port, which is dedicated to this block.
- Copies `length` bytes from `src_addr` to `dst_addr` inside the 64KB space, with memmove semantics: overlapping regions are copied correctly.
- CPU-side registers or a bus decoder load the parameters and pulse `start`.

---
 rtl/bram_dma_copy.sv | 164 ++++++++++++++++
 tb/tb_bram_dma_copy.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_dma_copy.sv
// rtl/bram_dma_copy.sv - memmove-style block copy engine driving one block RAM port
// Purpose: copies `length` bytes from src_addr to dst_addr. Overlapping regions are
//   handled by choosing the copy direction at start. Every byte takes three cycles:
//   RD (present the source address), CAP (capture the registered read data) and
//   WR (write to the destination).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        one-cycle request (accepted in IDLE only), cancel
//   src_addr, dst_addr  first source / destination byte address
//   length              byte count, 0 = no transfer
//   busy, done          transfer in progress, one-cycle completion pulse
//   mem_we, mem_addr,   registered RAM port controls
//   mem_dout, mem_din   write data out, registered read data in (1-cycle latency)
// Option: define BRAM_DMA_FILL_EN to add fill/fill_byte. A fill writes fill_byte to
//   `length` ascending addresses from dst_addr at one byte per cycle.
module bram_dma_copy #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
`ifdef BRAM_DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_byte,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_src_ptr, w_src_nxt;
  logic [ADDR_W-1:0] r_dst_ptr, w_dst_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_bwd, w_bwd_nxt;
  logic              r_fill, w_fill_nxt;
  logic [DATA_W-1:0] r_fill_byte, w_fill_byte_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_dout, w_mem_dout_nxt;
  logic              w_fill_in;
  logic [DATA_W-1:0] w_fill_byte_in;
  logic [ADDR_W-1:0] w_diff, w_len_m1;

`ifdef BRAM_DMA_FILL_EN
  assign w_fill_in      = fill;
  assign w_fill_byte_in = fill_byte;
`else
  assign w_fill_in      = 1'b0;
  assign w_fill_byte_in = '0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_src_nxt       = r_src_ptr;
    w_dst_nxt       = r_dst_ptr;
    w_cnt_nxt       = r_cnt;
    w_bwd_nxt       = r_bwd;
    w_fill_nxt      = r_fill;
    w_fill_byte_nxt = r_fill_byte;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_dout_nxt  = r_mem_dout;
    // Destination lies inside the source window (and is not equal to it):
    // a forward copy would overwrite bytes not yet read, so copy top-down.
    w_diff          = dst_addr - src_addr;
    w_len_m1        = length - ONE;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_cnt_nxt       = length;
          w_fill_nxt      = w_fill_in;
          w_fill_byte_nxt = w_fill_byte_in;
          w_bwd_nxt       = !w_fill_in && (w_diff != '0) && (w_diff < length);
          if (w_bwd_nxt) begin
            w_src_nxt = src_addr + w_len_m1;
            w_dst_nxt = dst_addr + w_len_m1;
          end else begin
            w_src_nxt = src_addr;
            w_dst_nxt = dst_addr;
          end
          if (length == '0)   w_state_nxt = S_DONE;
          else if (w_fill_in) w_state_nxt = S_WR;
          else                w_state_nxt = S_RD;
        end
      end
      S_RD:  w_state_nxt = S_CAP;
      S_CAP: w_state_nxt = S_WR;
      S_WR: begin
        if (r_bwd) begin
          w_src_nxt = r_src_ptr - ONE;
          w_dst_nxt = r_dst_ptr - ONE;
        end else begin
          w_src_nxt = r_src_ptr + ONE;
          w_dst_nxt = r_dst_ptr + ONE;
        end
        w_cnt_nxt = r_cnt - ONE;
        if (r_cnt == ONE) w_state_nxt = S_DONE;
        else if (r_fill)  w_state_nxt = S_WR;
        else              w_state_nxt = S_RD;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;

    // RAM port registers are loaded from the next state so that they show
    // the values belonging to a state during the cycle the FSM is in it.
    w_mem_we_nxt = (w_state_nxt == S_WR);
    if (w_state_nxt == S_RD)      w_mem_addr_nxt = w_src_nxt;
    else if (w_state_nxt == S_WR) w_mem_addr_nxt = w_dst_nxt;

    // The data register doubles as the captured read byte.
    if (r_state == S_CAP)                          w_mem_dout_nxt = mem_din;
    else if ((w_state_nxt == S_WR) && w_fill_nxt)  w_mem_dout_nxt = w_fill_byte_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_cnt       <= '0;
      r_bwd       <= 1'b0;
      r_fill      <= 1'b0;
      r_fill_byte <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_dout  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_src_ptr   <= w_src_nxt;
      r_dst_ptr   <= w_dst_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bwd       <= w_bwd_nxt;
      r_fill      <= w_fill_nxt;
      r_fill_byte <= w_fill_byte_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_dout  <= w_mem_dout_nxt;
    end
  end

  assign busy     = (r_state == S_RD) || (r_state == S_CAP) || (r_state == S_WR);
  assign done     = (r_state == S_DONE);
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_dout = r_mem_dout;

endmodule

// File: tb/tb_bram_dma_copy.sv
// tb/tb_bram_dma_copy.sv - self-checking bench for bram_dma_copy
module tb_bram_dma_copy;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW-1:0] length = '0;
  logic          busy, done, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] mem_din = '0;
`ifdef BRAM_DMA_FILL_EN
  logic          fill = 1'b0;
  logic [DW-1:0] fill_byte = '0;
`endif

  logic [7:0]  ram     [0:65535];
  logic [7:0]  exp_ram [0:65535];
  logic        tb_clr = 1'b0;
  logic        tb_we = 1'b0;
  logic [15:0] tb_addr = '0;
  logic [7:0]  tb_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_dma_copy #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
`ifdef BRAM_DMA_FILL_EN
    .fill(fill), .fill_byte(fill_byte),
`endif
    .busy(busy), .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din)
  );

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Synchronous RAM, registered read, single writer process.
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_byte(16'(i));
    end else if (tb_we) begin
      ram[tb_addr] <= tb_data;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_dout;
    end
    mem_din <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_ram(input string name);
    int nbad = 0;
    int first = 0;
    for (int i = 0; i < 65536; i++) begin
      if (ram[i] !== exp_ram[i]) begin
        if (nbad == 0) first = i;
        nbad++;
      end
    end
    checks++;
    if (nbad != 0) begin
      failures++;
      $display("FAIL %s: %0d bytes differ, first at %04h got %02h expected %02h",
               name, nbad, first, ram[16'(first)], exp_ram[16'(first)]);
    end
  endtask

  // Reference: memmove on an array (read the whole source, then write), or fill.
  task automatic model_op(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input bit f, input logic [7:0] fb);
    logic [7:0] tmp[$];
    for (int i = 0; i < int'(l); i++) tmp.push_back(exp_ram[16'(int'(s) + i)]);
    for (int i = 0; i < int'(l); i++) exp_ram[16'(int'(d) + i)] = f ? fb : tmp[i];
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    exp_ram[a] = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                        output int lat, output int nwr, output logic [15:0] fa,
                        output logic busy1, output logic busy_at_done,
                        output logic done_after, output logic ok);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    lat = 0; nwr = 0; fa = '0; ok = 1'b0; busy1 = 1'b0; busy_at_done = 1'b1; done_after = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      start = 1'b0;
      lat = k;
      if (k == 1) busy1 = busy;
      if (mem_we) begin
        if (nwr == 0) fa = mem_addr;
        nwr++;
      end
      if (done) begin
        ok = 1'b1;
        busy_at_done = busy;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    done_after = done;
  endtask

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    int          exp_lat;
    logic [15:0] exp_fa;
  } vec_t;

  initial begin
    vec_t        vt[8];
    int          lat, nwr, nw, ndone;
    logic [15:0] fa, s, d, l;
    logic        b1, bd, da, ok;
    logic [7:0]  pat_a[4];
    logic [7:0]  pat_b[5];

    vt[0] = '{16'h1000, 16'h2000, 16'd4, 13, 16'h2000};
    vt[1] = '{16'h3000, 16'h3002, 16'd5, 16, 16'h3006};
    vt[2] = '{16'hFFFE, 16'h0100, 16'd4, 13, 16'h0100};
    vt[3] = '{16'h1234, 16'h4321, 16'd0,  1, 16'h0000};
    vt[4] = '{16'h6000, 16'h6000, 16'd3, 10, 16'h6000};
    vt[5] = '{16'hFFFF, 16'h0001, 16'd3, 10, 16'h0003};
    vt[6] = '{16'h7002, 16'h7000, 16'd4, 13, 16'h7000};
    vt[7] = '{16'h8000, 16'h8004, 16'd4, 13, 16'h8004};
    pat_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    pat_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

    for (int i = 0; i < 65536; i++) exp_ram[i] = init_byte(16'(i));
    tb_clr = 1'b1;
    repeat (2) @(negedge clk);
    tb_clr = 1'b0;
    check("reset outputs", {busy, done, mem_we, mem_addr, mem_dout}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) preload(16'h1000 + 16'(i), pat_a[i]);
    for (int i = 0; i < 5; i++) preload(16'h3000 + 16'(i), pat_b[i]);

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].src, vt[i].dst, vt[i].len, lat, nwr, fa, b1, bd, da, ok);
      model_op(vt[i].src, vt[i].dst, vt[i].len, 1'b0, 8'h00);
      check($sformatf("vec%0d done seen", i), ok, 1'b1);
      check($sformatf("vec%0d latency", i), lat, vt[i].exp_lat);
      check($sformatf("vec%0d writes", i), nwr, vt[i].len);
      if (vt[i].len != 0) check($sformatf("vec%0d first wr addr", i), fa, vt[i].exp_fa);
      check($sformatf("vec%0d busy after start", i), b1, vt[i].len != 0);
      check($sformatf("vec%0d busy at done", i), bd, 1'b0);
      check($sformatf("vec%0d done one cycle", i), da, 1'b0);
      compare_ram($sformatf("vec%0d ram", i));
    end
    for (int i = 0; i < 4; i++) check($sformatf("fwd byte %0d", i), ram[16'h2000 + 16'(i)], pat_a[i]);
    for (int i = 0; i < 5; i++) check($sformatf("bwd byte %0d", i), ram[16'h3002 + 16'(i)], pat_b[i]);

    // Abort after the third write; a second start mid-transfer must be ignored.
    @(negedge clk);
    src_addr = 16'h9000; dst_addr = 16'hA000; length = 16'd10; start = 1'b1;
    nw = 0; ndone = 0;
    for (int k = 1; k <= 200 && nw < 3; k++) begin
      @(negedge clk);
      start = (k == 2);
      if (k == 2) begin
        src_addr = 16'hB000; dst_addr = 16'hC000; length = 16'd2;
      end
      if (mem_we) nw++;
      if (done) ndone++;
    end
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy next cycle", {busy, done, mem_we}, 3'b000);
    repeat (20) begin
      @(negedge clk);
      if (mem_we) nw++;
      if (done) ndone++;
    end
    model_op(16'h9000, 16'hA000, 16'd3, 1'b0, 8'h00);
    check("abort write count", nw, 3);
    check("abort no done", ndone, 0);
    compare_ram("abort ram");

    // Abort during CAP of the first byte: no write is ever issued.
    @(negedge clk);
    src_addr = 16'hF000; dst_addr = 16'hF100; length = 16'd2; start = 1'b1;
    nw = 0; ndone = 0;
    @(negedge clk); start = 1'b0; if (mem_we) nw++;
    @(negedge clk); abort = 1'b1; if (mem_we) nw++;
    @(negedge clk); abort = 1'b0;
    check("abort in CAP busy", busy, 1'b0);
    repeat (10) begin
      if (mem_we) nw++;
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort in CAP writes", nw, 0);
    check("abort in CAP done", ndone, 0);

    // Abort together with start in IDLE: the start is dropped.
    src_addr = 16'h0200; dst_addr = 16'h0300; length = 16'd4;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    nw = 0; ndone = 0;
    check("abort+start busy", busy, 1'b0);
    repeat (20) begin
      if (mem_we) nw++;
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort+start activity", {nw[7:0], ndone[7:0]}, 16'h0000);
    compare_ram("abort+start ram");

    // Reset dropped during CAP.
    src_addr = 16'hD000; dst_addr = 16'hE000; length = 16'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset mid outputs", {busy, done, mem_we, mem_addr, mem_dout}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nw = 0; ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_we) nw++;
      if (done) ndone++;
    end
    check("reset mid no activity", {nw[7:0], ndone[7:0]}, 16'h0000);
    compare_ram("reset mid ram");
    run_op(16'hD000, 16'hE000, 16'd5, lat, nwr, fa, b1, bd, da, ok);
    model_op(16'hD000, 16'hE000, 16'd5, 1'b0, 8'h00);
    check("post reset latency", lat, 16);
    check("post reset first wr", fa, 16'hE000);
    compare_ram("post reset ram");

    // Randomized copies, half of them with nearby (overlapping) windows.
    for (int r = 0; r < 16; r++) begin
      s = 16'($urandom);
      l = 16'($urandom_range(0, 40));
      if (r % 2 == 1) d = 16'(int'(s) + int'($urandom_range(0, 16)) - 8);
      else            d = 16'($urandom);
      run_op(s, d, l, lat, nwr, fa, b1, bd, da, ok);
      model_op(s, d, l, 1'b0, 8'h00);
      check($sformatf("rnd%0d s=%04h d=%04h l=%0d latency", r, s, d, l), lat, 3 * int'(l) + 1);
      check($sformatf("rnd%0d writes", r), nwr, l);
      compare_ram($sformatf("rnd%0d ram", r));
    end

`ifdef BRAM_DMA_FILL_EN
    fill = 1'b1; fill_byte = 8'hA5;
    run_op(16'h0000, 16'h4000, 16'd3, lat, nwr, fa, b1, bd, da, ok);
    fill = 1'b0;
    model_op(16'h0000, 16'h4000, 16'd3, 1'b1, 8'hA5);
    check("fill latency", lat, 4);
    check("fill writes", nwr, 3);
    check("fill first wr", fa, 16'h4000);
    compare_ram("fill ram");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
